// File: rtl/spi_pkg.sv
// Shared types for the SPI slave front end: FSM state encoding, command codes,
// and the command/state legality rule used when SPI_SLAVE_CMD_CHECK_EN is defined.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // True when the command bits of a finished word belong to the state that received it.
    function automatic logic cmd_ok(input spi_state_e st, input logic [1:0] cmd);
        case (st)
            WRITE:     return (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
            READ_ADD:  return cmd == CMD_RD_ADDR;
            READ_DATA: return cmd == CMD_RD_DATA;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO serialiser: latches a RAM word on start and shifts it out MSB first,
// one bit per clock; busy covers the whole shift, MISO is 0 when idle.
module spi_tx_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         start,
    input  logic [W-1:0] tx_data,
    output logic         busy,
    output logic         miso
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  data_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            data_q <= tx_data;
            cnt_q  <= CW'(W);
        end else if (cnt_q != '0) begin
            data_q <= data_q << 1;
            cnt_q  <= cnt_q - CW'(1);
        end
    end

    assign busy = (cnt_q != '0);
    assign miso = busy & data_q[W-1];

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end for the RAM: deserialises command+payload words and
// serialises read data onto MISO. Optional macro: SPI_SLAVE_CMD_CHECK_EN.
module spi_slave_fsm
    import spi_pkg::*;
#(
    parameter  int MEM_DEPTH = 256,
    localparam int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 cmd_err,
    output spi_state_e           state_dbg
);

    localparam int N     = ADDR_SIZE + 2;
    localparam int CNT_W = $clog2(N + 1);

    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [N-2:0]     shreg_q, shreg_d;
    logic             word_done_q, word_done_d;
    logic             tx_started_q, tx_started_d;
    logic             addr_rcvd_q, addr_rcvd_d;
    logic [N-1:0]     rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             cmd_err_q, cmd_err_d;
    logic             tx_start, tx_clear, tx_busy;
    logic [N-1:0]     word;
    logic             word_ok;

    assign word = {shreg_q, MOSI};

`ifdef SPI_SLAVE_CMD_CHECK_EN
    assign word_ok = cmd_ok(state_q, word[N-1:N-2]);
`else
    assign word_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            word_done_q  <= 1'b0;
            tx_started_q <= 1'b0;
            addr_rcvd_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            word_done_q  <= word_done_d;
            tx_started_q <= tx_started_d;
            addr_rcvd_q  <= addr_rcvd_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        word_done_d  = word_done_q;
        tx_started_d = tx_started_q;
        addr_rcvd_d  = addr_rcvd_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        cmd_err_d    = 1'b0;
        tx_start     = 1'b0;
        tx_clear     = 1'b0;

        // Deselect ends any frame: partial words and MISO shifts are dropped, addr_rcvd survives.
        if ((state_q != IDLE) && SS_n) begin
            state_d      = IDLE;
            bit_cnt_d    = '0;
            shreg_d      = '0;
            word_done_d  = 1'b0;
            tx_started_d = 1'b0;
            tx_clear     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!SS_n) state_d = CHK_CMD;
                end
                CHK_CMD: begin
                    if (!MOSI)            state_d = WRITE;
                    else if (addr_rcvd_q) state_d = READ_DATA;
                    else                  state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!word_done_q) begin
                        shreg_d = {shreg_q[N-3:0], MOSI};
                        if (bit_cnt_q == CNT_W'(N - 1)) begin
                            word_done_d = 1'b1;
                            bit_cnt_d   = '0;
                            rx_data_d   = word;
                            if (word_ok) begin
                                rx_valid_d = 1'b1;
                                if (state_q == READ_ADD)  addr_rcvd_d = 1'b1;
                                if (state_q == READ_DATA) addr_rcvd_d = 1'b0;
                            end else begin
                                // A rejected read-data word never waits for RAM data.
                                cmd_err_d    = 1'b1;
                                tx_started_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if ((state_q == READ_DATA) && !tx_started_q && !tx_busy && tx_valid) begin
                        tx_start     = 1'b1;
                        tx_started_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    spi_tx_shifter #(.W(ADDR_SIZE)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .clear   (tx_clear),
        .start   (tx_start),
        .tx_data (tx_data),
        .busy    (tx_busy),
        .miso    (MISO)
    );

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign cmd_err   = cmd_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Bench for spi_slave_fsm: constant vector table, directed corner sequences and
// random frames checked against a frame-level model (expected word queue + MISO bit queue).
module tb_spi_slave_fsm;
    import spi_pkg::*;

    localparam int MEM_DEPTH = 256;
    localparam int AW = 8;
    localparam int N  = 10;
`ifdef SPI_SLAVE_CMD_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, SS_n, MOSI, tx_valid;
    logic [AW-1:0] tx_data;
    logic          MISO, rx_valid, cmd_err;
    logic [N-1:0]  rx_data;
    spi_state_e    state_dbg;

    always #5 clk = ~clk;

    spi_slave_fsm #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .cmd_err   (cmd_err),
        .state_dbg (state_dbg)
    );

    // Scoreboard and model state
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [N-1:0] exp_q[$];
    logic         miso_q[$];
    logic         nxt_rxv = 1'b0;
    logic         nxt_err = 1'b0;
    logic         m_addr_rcvd = 1'b0;
    logic [7:0]   miso_hist = '0;
    logic         seen_rxv;
    logic [N-1:0] seen_data;
    int           seen_err;

    typedef struct {
        logic         sel;
        logic [N-1:0] word;
        logic         exp_valid;
        logic [N-1:0] exp_data;
        logic         exp_err;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input int kind, input logic [1:0] cmd);
        if (!CHK) return 1'b1;
        case (kind)
            0:       return cmd[1] == 1'b0;
            1:       return cmd == 2'b10;
            default: return cmd == 2'b11;
        endcase
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic noise_txv(input logic noise);
        return noise && ($urandom_range(0, 3) == 0);
    endfunction

    // One clock: drive inputs, then check the outputs of the following cycle.
    task automatic cyc(input logic ss, input logic mosi, input logic txv, input logic [AW-1:0] txd);
        logic [N-1:0] e;
        logic         em;
        SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
        if (ss) miso_q.delete();
        @(posedge clk); #1;
        em = (miso_q.size() > 0) ? miso_q.pop_front() : 1'b0;
        miso_hist = {miso_hist[6:0], MISO};
        check("miso", 32'(MISO), 32'(em));
        check("rx_valid", 32'(rx_valid), 32'(nxt_rxv));
        if (rx_valid) begin seen_rxv = 1'b1; seen_data = rx_data; end
        if (nxt_rxv) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            check("rx_data", 32'(rx_data), 32'(e));
        end
        check("cmd_err", 32'(cmd_err), 32'(nxt_err));
        if (cmd_err) seen_err++;
        nxt_rxv = 1'b0;
        nxt_err = 1'b0;
    endtask

    task automatic do_reset(input int cycles, input logic ss);
        rst = 1'b1; SS_n = ss; MOSI = rnd_bit(); tx_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check("rst_miso", 32'(MISO), 0);
            check("rst_rx_valid", 32'(rx_valid), 0);
            check("rst_rx_data", 32'(rx_data), 0);
            check("rst_cmd_err", 32'(cmd_err), 0);
            check("rst_state", 32'(state_dbg), 32'(IDLE));
        end
        rst = 1'b0;
        m_addr_rcvd = 1'b0;
        miso_q.delete();
        exp_q.delete();
        nxt_rxv = 1'b0;
        nxt_err = 1'b0;
    endtask

    // nbits = N for a full word, 0..N-1 aborts after that many bits, -1 aborts on the selector.
    // tx_wait < 0 sends no RAM reply; otherwise the reply follows the rx_valid cycle plus tx_wait cycles.
    task automatic frame(input logic sel, input logic [N-1:0] word, input int nbits, input int tx_wait,
                         input logic [AW-1:0] txd, input int hold, input int gap, input logic noise,
                         output logic [7:0] miso_cap);
        int   kind;
        logic ok, waiting;
        spi_state_e exp_st;
        kind = !sel ? 0 : (m_addr_rcvd ? 2 : 1);
        ok = legal(kind, word[N-1:N-2]);
        exp_st = (kind == 0) ? WRITE : ((kind == 1) ? READ_ADD : READ_DATA);
        seen_rxv = 1'b0; seen_data = '0; seen_err = 0; miso_cap = '0;
        cyc(1'b0, rnd_bit(), noise_txv(noise), AW'($urandom));
        if (nbits < 0) begin
            cyc(1'b1, rnd_bit(), 1'b0, AW'($urandom));
            check("idle_after_abort", 32'(state_dbg), 32'(IDLE));
            for (int g = 1; g < gap; g++) cyc(1'b1, rnd_bit(), 1'b0, AW'($urandom));
            return;
        end
        cyc(1'b0, sel, noise_txv(noise), AW'($urandom));
        check("state_after_sel", 32'(state_dbg), 32'(exp_st));
        for (int i = 0; i < ((nbits < N) ? nbits : N); i++) begin
            if (i == N - 1) begin
                if (ok) begin
                    nxt_rxv = 1'b1;
                    exp_q.push_back(word);
                    if (kind == 1) m_addr_rcvd = 1'b1;
                    if (kind == 2) m_addr_rcvd = 1'b0;
                end else begin
                    nxt_err = 1'b1;
                end
            end
            cyc(1'b0, word[N-1-i], noise_txv(noise), AW'($urandom));
        end
        if (nbits < N) begin
            cyc(1'b1, rnd_bit(), 1'b0, AW'($urandom));
            check("idle_after_abort", 32'(state_dbg), 32'(IDLE));
            for (int g = 1; g < gap; g++) cyc(1'b1, rnd_bit(), 1'b0, AW'($urandom));
            return;
        end
        waiting = (kind == 2) && ok;
        if (waiting && tx_wait >= 0) begin
            cyc(1'b0, rnd_bit(), 1'b0, AW'($urandom));
            for (int w = 0; w < tx_wait; w++) cyc(1'b0, rnd_bit(), 1'b0, AW'($urandom));
            for (int b = AW - 1; b >= 0; b--) miso_q.push_back(txd[b]);
            cyc(1'b0, rnd_bit(), 1'b1, txd);
            waiting = 1'b0;
            for (int h = 0; h < hold; h++) begin
                cyc(1'b0, rnd_bit(), noise_txv(noise), AW'($urandom));
                if (h == AW - 2) miso_cap = miso_hist;
            end
        end else begin
            for (int h = 0; h < hold; h++)
                cyc(1'b0, rnd_bit(), waiting ? 1'b0 : noise_txv(noise), AW'($urandom));
        end
        for (int g = 0; g < gap; g++) cyc(1'b1, rnd_bit(), 1'b0, AW'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   cap;
        logic [N-1:0] w;
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;

        // Clock/reset
        do_reset(2, 1'b1);

        // Table-driven frames from reset (addr_rcvd starts at 0)
        vecs[0] = '{1'b0, 10'h0A5, 1'b1, 10'h0A5, 1'b0};
        vecs[1] = '{1'b0, 10'h1F0, 1'b1, 10'h1F0, 1'b0};
        vecs[2] = '{1'b1, 10'h233, 1'b1, 10'h233, 1'b0};
        vecs[3] = '{1'b1, 10'h300, 1'b1, 10'h300, 1'b0};
        vecs[4] = '{1'b0, 10'h201, !CHK,  10'h201, CHK};
        vecs[5] = '{1'b1, 10'h2FF, 1'b1, 10'h2FF, 1'b0};
        vecs[6] = '{1'b1, 10'h3AB, 1'b1, 10'h3AB, 1'b0};
        vecs[7] = '{1'b0, 10'h000, 1'b1, 10'h000, 1'b0};
        vecs[8] = '{1'b0, 10'h3FF, !CHK,  10'h3FF, CHK};
        for (int i = 0; i < 9; i++) begin
            frame(vecs[i].sel, vecs[i].word, N, -1, '0, 3, 2, 1'b1, cap);
            check("tbl_valid", 32'(seen_rxv), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check("tbl_data", 32'(seen_data), 32'(vecs[i].exp_data));
            check("tbl_err", 32'(seen_err != 0), 32'(vecs[i].exp_err));
        end

        // Write address, then MOSI kept toggling while selected must be ignored
        frame(1'b0, 10'h0A5, N, -1, '0, 15, 1, 1'b1, cap);
        check("wr_hold_data", 32'(rx_data), 32'h0A5);

        // Read pair with RAM reply 0x5C
        do_reset(2, 1'b1);
        frame(1'b1, 10'h233, N, -1, '0, 2, 1, 1'b0, cap);
        check("rd_addr_data", 32'(seen_data), 32'h233);
        frame(1'b1, 10'h300, N, 2, 8'h5C, 12, 2, 1'b1, cap);
        check("rd_data_data", 32'(seen_data), 32'h300);
        check("miso_5c", 32'(cap), 32'h5C);

        // Abort after 5 bits, then a full write-data frame
        frame(1'b0, 10'h155, 5, -1, '0, 0, 1, 1'b0, cap);
        check("abort_no_valid", 32'(seen_rxv), 0);
        frame(1'b0, 10'h1F0, N, -1, '0, 1, 1, 1'b0, cap);
        check("after_abort_data", 32'(seen_data), 32'h1F0);

        // Reset mid-frame with SS_n still low
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc(1'b0, rnd_bit(), 1'b0, '0);
        do_reset(2, 1'b0);
        frame(1'b0, 10'h0C3, N, -1, '0, 1, 1, 1'b0, cap);
        check("post_rst_data", 32'(seen_data), 32'h0C3);

        // Reset during the MISO shift, three bits in
        frame(1'b1, 10'h211, N, -1, '0, 1, 1, 1'b0, cap);
        w = 10'h3C0;
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin nxt_rxv = 1'b1; exp_q.push_back(w); m_addr_rcvd = 1'b0; end
            cyc(1'b0, w[N-1-i], 1'b0, '0);
        end
        cyc(1'b0, 1'b0, 1'b0, '0);
        for (int b = AW - 1; b >= 0; b--) miso_q.push_back(1'b1);
        cyc(1'b0, 1'b0, 1'b1, 8'hFF);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        do_reset(1, 1'b1);
        frame(1'b1, 10'h2AA, N, -1, '0, 1, 1, 1'b0, cap);
        check("post_rst_read_add", 32'(seen_data), 32'h2AA);

        // Random frames against the model
        for (int f = 0; f < 40; f++) begin
            int nb, tw;
            nb = ($urandom_range(0, 9) < 7) ? N : (int'($urandom_range(0, N)) - 1);
            tw = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 4));
            frame(rnd_bit(), N'($urandom), nb, tw, AW'($urandom),
                  int'($urandom_range(0, 12)), int'($urandom_range(1, 3)), 1'b1, cap);
        end

        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
